// File: rtl/uart_tx_buffer_if.sv
// rtl/uart_tx_buffer_if.sv - host write, baud tick and serial-line signal bundle for uart_tx_buffer
interface uart_tx_buffer_if #(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 4
);
  logic                   wr;
  logic [BITWIDTH-1:0]    data_in;
  logic                   baud_tick;
  logic                   txd;
  logic                   full;
  logic                   empty;
  logic                   busy;
  logic [$clog2(DEPTH):0] count;
  logic                   ovr;

  modport master (output wr, data_in, baud_tick, input txd, full, empty, busy, count, ovr);
  modport slave  (input wr, data_in, baud_tick, output txd, full, empty, busy, count, ovr);
endinterface

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO drained by a baud-tick-paced start/data/stop serializer
module uart_tx_buffer #(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BITWIDTH) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BITWIDTH-1:0] shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                ovr_q, ovr_d;
  logic [BITWIDTH-1:0] mem [DEPTH];

  logic full, empty, push, pop;

  // Flags come from the pre-edge count, so a pop cannot make room for a write on the same edge.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.wr && !full;
  assign pop   = bus.baud_tick && !empty && ((state_q == IDLE) || (state_q == STOP));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovr_d     = ovr_q | (bus.wr & full);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // txd_d is the line level of the state being entered, so TxD moves only on tick edges.
    if (bus.baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            state_d = START;
            shift_d = mem[rd_ptr_q];
            txd_d   = 1'b0;
          end
        end
        START: begin
          state_d   = DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
        DATA: begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(BITWIDTH - 1)) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            txd_d = shift_d[0];
          end
        end
        STOP: begin
          if (!empty) begin
            state_d = START;
            shift_d = mem[rd_ptr_q];
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ovr_q     <= ovr_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.txd   = txd_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.busy  = (state_q != IDLE);
  assign bus.count = count_q;
  assign bus.ovr   = ovr_q;
endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Transmit-side counterpart to the UART receive buffer: a small FIFO that the host writes bytes into, plus a serializer that drains it onto the serial line as 8N1-style frames (one start bit, BITWIDTH data bits sent LSB first, one stop bit). It sits between the host write port and the TxD pin. Bit timing comes from an externally generated one-cycle BaudTick pulse. The block reports FULL, EMPTY and BUSY for host flow control.

## Interface
- BITWIDTH, 8, data bits per frame and FIFO word width
- DEPTH, 4, number of FIFO entries; must be a power of two; pointer width is log2(DEPTH)

- Clk  in  1  system clock; all state updates on the rising edge
- Rst  in  1  asynchronous, active-high reset
- WR  in  1  write strobe; pushes dataIn when FULL=0
- dataIn  in  BITWIDTH  byte to enqueue
- BaudTick  in  1  one-Clk pulse per bit period
- TxD  out  1  serial output; idle level 1
- FULL  out  1  FIFO holds DEPTH entries
- EMPTY  out  1  FIFO holds 0 entries
- BUSY  out  1  serializer is not in IDLE
- COUNT  out  log2(DEPTH)+1  number of occupied entries
- OVR  out  1  sticky overrun flag: a WR was dropped while FULL

## Operation
- FIFO: circular memory with write pointer and read pointer, each log2(DEPTH) bits wide; both wrap modulo DEPTH.
- Push: on a Clk edge where WR=1 and FULL=0, store dataIn at the write pointer, then increment the write pointer.
- Dropped write: WR=1 while FULL=1 is discarded, and OVR sets to 1. OVR clears only on Rst.
- FULL and EMPTY are decoded from COUNT as it stands before the edge. A write while FULL is dropped even if a pop happens on the same edge.
- COUNT update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Serializer FSM states: IDLE, START, DATA, STOP. A bit counter (log2(BITWIDTH)+1 bits) and a BITWIDTH-bit shift register support it.
  - IDLE: TxD=1. If BaudTick=1 and EMPTY=0: pop the head into the shift register, advance the read pointer, go to START.
  - START: TxD=0. On BaudTick: go to DATA and clear the bit counter.
  - DATA: TxD=shift[0]. On BaudTick: shift right and increment the bit counter. After the BITWIDTH-th tick in DATA, go to STOP.
  - STOP: TxD=1. On BaudTick:
    - if EMPTY=0, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- BUSY = (state != IDLE).
- TxD is registered and changes only on the edge that samples BaudTick (or on reset).

## Timing
- Reset values (asynchronous, take effect immediately): state=IDLE, TxD=1, pointers=0, COUNT=0, EMPTY=1, FULL=0, BUSY=0, OVR=0, shift register=0, bit counter=0.
- Reset asserted mid-frame aborts the frame: TxD returns to 1 at once and all queued data is lost.
- Push latency: FULL, EMPTY and COUNT reflect a push one Clk after the WR edge.
- Frame start: TxD falls on the first BaudTick edge at which EMPTY=0 is sampled in IDLE or STOP.
- Bit duration:
  - every bit lasts exactly one BaudTick interval;
  - a frame lasts BITWIDTH+2 intervals;
  - consecutive queued bytes are sent with zero idle intervals between them.
- Empty FIFO with WR and BaudTick on the same edge: no pop on that edge, because EMPTY is evaluated pre-edge. The frame starts on the next BaudTick.
- BaudTick is sampled only in Clk cycles; a tick held high for several cycles counts once per cycle, and the integrator must keep it to one cycle.

## Test plan
- Reset, then WR with dataIn=8'hA5, BaudTick every 4 Clk.
  - Required: TxD sequence per tick interval is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop).
  - Required: BUSY=1 from the start bit through the stop bit, then BUSY=0, EMPTY=1.
- Write 8'h11, 8'h22, 8'h33 back-to-back.
  - Required: three contiguous 10-bit frames with no idle bit between them.
  - Required: COUNT steps 1,2,3 during the writes, then decrements at each pop.
- Hold BaudTick=0 and write 5 bytes 8'h01..8'h05.
  - Required: FULL=1 after the 4th write, COUNT=4, OVR=1 after the 5th.
  - Required: the transmitted order is 01,02,03,04; 05 never appears.
- Pointer wrap: with BaudTick running, write 6 bytes 8'hC0..8'hC5 at intervals that keep the FIFO non-full.
  - Required: all six are sent in order and COUNT returns to 0.
- FULL with a pop on the same edge: with FIFO full, assert WR (dataIn=8'hEE) on the edge where the STOP-state BaudTick pops.
  - Required: the write is dropped, OVR=1, COUNT goes 4→3.
- Assert Rst during the DATA state of frame 8'h3C, with 2 entries queued.
  - Required: TxD=1 immediately, COUNT=0, EMPTY=1, BUSY=0.
  - Required: no further frames after Rst deasserts until a new WR.
